// File: rtl/pc_fetch_seq_if.sv
// pc_fetch_seq_if
//   Bundles the fetch sequencer's memory, decode and PC-compute signals.
//   master : the fetch sequencer (drives PC, memory request, held instruction).
//   slave  : the environment (memory, decode, PC-compute stage).
//   Signals:
//     next_pc    PC_W  next PC from PC-compute stage (meaningful while inst_valid)
//     cur_pc     PC_W  current PC to PC-compute stage
//     imem_addr  PC_W  instruction memory address
//     imem_req   1     fetch request
//     imem_rdata PC_W  instruction word from memory
//     imem_valid 1     imem_rdata valid this cycle
//     inst       PC_W  held instruction to decode
//     inst_pc    PC_W  PC of held instruction
//     inst_valid 1     inst/inst_pc valid
//     inst_ready 1     decode accepts inst this cycle
//     halted     1     halt instruction retired
//     retired    16    count of accepted instructions, wraps
interface pc_fetch_seq_if #(
    parameter int PC_W = 16
);
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] cur_pc;
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic [PC_W-1:0] imem_rdata;
    logic            imem_valid;
    logic [PC_W-1:0] inst;
    logic [PC_W-1:0] inst_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic            halted;
    logic [15:0]     retired;

    modport master (
        input  next_pc,
        output cur_pc,
        output imem_addr,
        output imem_req,
        input  imem_rdata,
        input  imem_valid,
        output inst,
        output inst_pc,
        output inst_valid,
        input  inst_ready,
        output halted,
        output retired
    );

    modport slave (
        output next_pc,
        input  cur_pc,
        input  imem_addr,
        input  imem_req,
        output imem_rdata,
        output imem_valid,
        input  inst,
        input  inst_pc,
        input  inst_valid,
        output inst_ready,
        input  halted,
        input  retired
    );
endinterface

// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq
//   Owns the architectural PC and sequences instruction fetch for the
//   single-issue core: requests one word at a time from instruction memory,
//   holds it for decode under a valid/ready handshake, takes the next PC from
//   the PC-compute stage on accept, and stops permanently on a halt opcode.
//   Ports:
//     clk    in  system clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    master side of pc_fetch_seq_if (memory, decode, PC loop)
module pc_fetch_seq #(
    parameter int              PC_W       = 16,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter logic [3:0]      HLT_OPCODE = 4'hF
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_fetch_seq_if.master bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t          state_q,   state_d;
    logic [PC_W-1:0] pc_q,      pc_d;
    logic [PC_W-1:0] inst_q,    inst_d;
    logic [PC_W-1:0] inst_pc_q, inst_pc_d;
    logic [15:0]     retired_q, retired_d;

    // PC is halfword aligned; bit 0 of any incoming target is dropped.
    function automatic logic [PC_W-1:0] align_halfword(input logic [PC_W-1:0] addr);
        return addr & ~{{(PC_W-1){1'b0}}, 1'b1};
    endfunction

    // ---- State registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            retired_q <= retired_d;
        end
    end

    // ---- Next-state logic ----
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        retired_d = retired_q;

        case (state_q)
            // One idle cycle after reset release before the first request.
            BOOT: state_d = FETCH;

            FETCH: begin
                if (bus.imem_valid) begin
                    inst_d    = bus.imem_rdata;
                    inst_pc_d = pc_q;
                    state_d   = HOLD;
                end
            end

            HOLD: begin
                if (bus.inst_ready) begin
                    retired_d = retired_q + 16'd1;
                    // A halt retires but leaves the PC where it is.
                    if (inst_q[PC_W-1 -: 4] == HLT_OPCODE) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = align_halfword(bus.next_pc);
                        state_d = FETCH;
                    end
                end
            end

            HALT: state_d = HALT;

            default: state_d = BOOT;
        endcase
    end

    // ---- Outputs: registered state or decoded from state ----
    assign bus.cur_pc     = pc_q;
    assign bus.imem_addr  = pc_q;
    assign bus.imem_req   = (state_q == FETCH);
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_valid = (state_q == HOLD);
    assign bus.halted     = (state_q == HALT);
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// tb_pc_fetch_seq
//   Directed bench for pc_fetch_seq: reset, fetch with memory wait states,
//   decode stall, PC alignment and wrap, back-to-back instructions, halt,
//   asynchronous reset mid-transaction and retired-count wrap.
module tb_pc_fetch_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pc_fetch_seq_if #(.PC_W(16)) bus ();

    pc_fetch_seq #(
        .PC_W      (16),
        .RESET_PC  (16'h0000),
        .HLT_OPCODE(4'hF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Present one memory word after nwait idle FETCH cycles.
    task automatic deliver(input logic [15:0] data, input int nwait);
        repeat (nwait) @(negedge clk);
        bus.imem_valid = 1'b1;
        bus.imem_rdata = data;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 16'h0000;
    endtask

    // Decode accepts the held instruction for one cycle.
    task automatic accept(input logic [15:0] npc);
        bus.next_pc    = npc;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        bus.next_pc    = 16'h0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.cur_pc !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h want %h", bus.cur_pc, 16'h0000); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_ival: got %b want 0", bus.inst_valid); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", bus.halted); end
        checks++; if (bus.retired !== 16'h0000) begin errors++; $display("FAIL rst_retired: got %h want 0000", bus.retired); end
        checks++; if (bus.inst !== 16'h0000) begin errors++; $display("FAIL rst_inst: got %h want 0000", bus.inst); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b want 0", bus.imem_req); end
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL first_addr: got %h want 0000", bus.imem_addr); end
    endtask

    task automatic test_fetch_wait();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL wait_req[%0d]: got %b want 1", i, bus.imem_req); end
        end
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 16'h1234;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 16'h0000;
        checks++; if (bus.inst !== 16'h1234) begin errors++; $display("FAIL cap_inst: got %h want 1234", bus.inst); end
        checks++; if (bus.inst_pc !== 16'h0000) begin errors++; $display("FAIL cap_inst_pc: got %h want 0000", bus.inst_pc); end
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL cap_ival: got %b want 1", bus.inst_valid); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b want 0", bus.imem_req); end
    endtask

    task automatic test_hold_stall();
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.next_pc    = (i % 2 == 1) ? 16'hAAAA : 16'h5554;
            bus.imem_valid = (i == 1);
            bus.imem_rdata = 16'hBEEF;
            @(negedge clk);
            checks++; if (bus.inst !== 16'h1234) begin errors++; $display("FAIL stall_inst[%0d]: got %h want 1234", i, bus.inst); end
            checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL stall_ival[%0d]: got %b want 1", i, bus.inst_valid); end
            checks++; if (bus.cur_pc !== 16'h0000) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 0000", i, bus.cur_pc); end
        end
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 16'h0000;
        accept(16'h0040);
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL acc_req: got %b want 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 16'h0040) begin errors++; $display("FAIL acc_addr: got %h want 0040", bus.imem_addr); end
        checks++; if (bus.retired !== 16'd1) begin errors++; $display("FAIL acc_retired: got %h want 0001", bus.retired); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL acc_ival: got %b want 0", bus.inst_valid); end
    endtask

    task automatic test_pc_align();
        deliver(16'h2000, 0);
        checks++; if (bus.inst_pc !== 16'h0040) begin errors++; $display("FAIL al_inst_pc: got %h want 0040", bus.inst_pc); end
        checks++; if (bus.inst !== 16'h2000) begin errors++; $display("FAIL al_inst: got %h want 2000", bus.inst); end
        accept(16'h0013);
        checks++; if (bus.cur_pc !== 16'h0012) begin errors++; $display("FAIL al_odd_pc: got %h want 0012", bus.cur_pc); end
        checks++; if (bus.retired !== 16'd2) begin errors++; $display("FAIL al_retired: got %h want 0002", bus.retired); end
        deliver(16'h3000, 2);
        checks++; if (bus.inst_pc !== 16'h0012) begin errors++; $display("FAIL al_inst_pc2: got %h want 0012", bus.inst_pc); end
        accept(16'hFFFE);
        checks++; if (bus.cur_pc !== 16'hFFFE) begin errors++; $display("FAIL al_top_pc: got %h want fffe", bus.cur_pc); end
        deliver(16'h4000, 0);
        checks++; if (bus.inst_pc !== 16'hFFFE) begin errors++; $display("FAIL al_inst_pc3: got %h want fffe", bus.inst_pc); end
        accept(16'h0000);
        checks++; if (bus.cur_pc !== 16'h0000) begin errors++; $display("FAIL al_wrap_pc: got %h want 0000", bus.cur_pc); end
        checks++; if (bus.retired !== 16'd4) begin errors++; $display("FAIL al_retired2: got %h want 0004", bus.retired); end
    endtask

    task automatic test_back_to_back();
        deliver(16'h5000, 0);
        accept(16'h0100);
        checks++; if (bus.imem_addr !== 16'h0100) begin errors++; $display("FAIL b2b_addr: got %h want 0100", bus.imem_addr); end
        deliver(16'h6001, 0);
        checks++; if (bus.inst !== 16'h6001) begin errors++; $display("FAIL b2b_inst: got %h want 6001", bus.inst); end
        accept(16'h0200);
        checks++; if (bus.retired !== 16'd6) begin errors++; $display("FAIL b2b_retired: got %h want 0006", bus.retired); end
        checks++; if (bus.cur_pc !== 16'h0200) begin errors++; $display("FAIL b2b_pc: got %h want 0200", bus.cur_pc); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL b2b_req: got %b want 1", bus.imem_req); end
    endtask

    task automatic test_halt();
        deliver(16'hF000, 0);
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL hlt_early: got %b want 0", bus.halted); end
        accept(16'h0300);
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL hlt_halted: got %b want 1", bus.halted); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL hlt_req: got %b want 0", bus.imem_req); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL hlt_ival: got %b want 0", bus.inst_valid); end
        checks++; if (bus.cur_pc !== 16'h0200) begin errors++; $display("FAIL hlt_pc: got %h want 0200", bus.cur_pc); end
        checks++; if (bus.retired !== 16'd7) begin errors++; $display("FAIL hlt_retired: got %h want 0007", bus.retired); end
        for (int i = 0; i < 20; i++) begin
            bus.inst_ready = 1'b1;
            bus.imem_valid = i[0];
            bus.imem_rdata = 16'h1357;
            bus.next_pc    = 16'h0400;
            @(negedge clk);
            checks++; if (bus.cur_pc !== 16'h0200) begin errors++; $display("FAIL hlt_frozen_pc[%0d]: got %h want 0200", i, bus.cur_pc); end
            checks++; if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
                errors++; $display("FAIL hlt_stay[%0d]: got halted=%b req=%b ival=%b want 1 0 0", i, bus.halted, bus.imem_req, bus.inst_valid);
            end
            checks++; if (bus.retired !== 16'd7) begin errors++; $display("FAIL hlt_frozen_ret[%0d]: got %h want 0007", i, bus.retired); end
        end
        bus.inst_ready = 1'b0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 16'h0000;
        bus.next_pc    = 16'h0000;
    endtask

    task automatic test_reset_mid();
        // Out of HALT.
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rh_halted: got %b want 0", bus.halted); end
        checks++; if (bus.retired !== 16'h0000) begin errors++; $display("FAIL rh_retired: got %h want 0000", bus.retired); end
        checks++; if (bus.cur_pc !== 16'h0000) begin errors++; $display("FAIL rh_pc: got %h want 0000", bus.cur_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        deliver(16'h1111, 0);
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL rm_hold: got %b want 1", bus.inst_valid); end
        // Mid-HOLD, between clock edges.
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rm_hold_ival: got %b want 0", bus.inst_valid); end
        checks++; if (bus.inst !== 16'h0000) begin errors++; $display("FAIL rm_hold_inst: got %h want 0000", bus.inst); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rm_fetch_req: got %b want 1", bus.imem_req); end
        // Mid-FETCH; memory answers late, during and just after reset.
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rm_fetch_rst: got %b want 0", bus.imem_req); end
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 16'hAAAA;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rm_boot_req: got %b want 0", bus.imem_req); end
        @(negedge clk);
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 16'h0000;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rm_late_ival: got %b want 0", bus.inst_valid); end
        checks++; if (bus.inst !== 16'h0000) begin errors++; $display("FAIL rm_late_inst: got %h want 0000", bus.inst); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rm_late_req: got %b want 1", bus.imem_req); end
    endtask

    task automatic test_retired_wrap();
        // Preload the counter near the top instead of retiring 65534 instructions.
        force dut.retired_q = 16'hFFFE;
        #1;
        release dut.retired_q;
        deliver(16'h1000, 0);
        accept(16'h0002);
        checks++; if (bus.retired !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h want ffff", bus.retired); end
        checks++; if (bus.cur_pc !== 16'h0002) begin errors++; $display("FAIL wrap_pc: got %h want 0002", bus.cur_pc); end
        deliver(16'h1000, 0);
        accept(16'h0004);
        checks++; if (bus.retired !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", bus.retired); end
    endtask

    initial begin
        bus.next_pc    = 16'h0000;
        bus.imem_rdata = 16'h0000;
        bus.imem_valid = 1'b0;
        bus.inst_ready = 1'b0;
        test_reset();
        test_fetch_wait();
        test_hold_stall();
        test_pc_align();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        test_retired_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
